// File: rtl/mux_16bit_arbiter_if.sv
// Handshake bundle for the two-requester mux arbiter.
// Master drives the requests and consumer ready; slave is the arbiter.
interface mux_16bit_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sel;

  modport master (
    output a_data, a_valid,
    output b_data, b_valid,
    output out_ready,
    input  a_ready, b_ready,
    input  out_data, out_valid, out_sel
  );

  modport slave (
    input  a_data, a_valid,
    input  b_data, b_valid,
    input  out_ready,
    output a_ready, b_ready,
    output out_data, out_valid, out_sel
  );
endinterface

// File: rtl/mux_16bit_arbiter.sv
// Round-robin two-requester arbiter with a registered 16-bit mux output.
// Define ARB_BURST_EN to allow up to MAX_BURST back-to-back grants.
module mux_16bit_arbiter #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst_n,
  mux_16bit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD_A,
    HOLD_B
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             sel_q;
  logic             last_sel;
  logic             out_v;
  logic             can_load;
  logic             win_b;
  logic             accept;

  assign out_v    = (state != IDLE);
  assign can_load = !out_v | bus.out_ready;

`ifdef ARB_BURST_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  logic [BW-1:0] burst_cnt;
  logic          keep;

  // A zero count means no grant history yet, so the other side wins.
  assign keep  = (burst_cnt != '0) && (burst_cnt < BMAX);
  assign win_b = bus.b_valid &
                 (!bus.a_valid | (keep ? last_sel : !last_sel));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (accept) begin
      if (win_b == last_sel && burst_cnt != '0) begin
        if (burst_cnt != BMAX)
          burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= BW'(1);
      end
    end
  end
`else
  logic unused_max_burst;

  assign unused_max_burst = |MAX_BURST;
  assign win_b = bus.b_valid & (!bus.a_valid | !last_sel);
`endif

  assign bus.a_ready = rst_n & can_load & bus.a_valid & !win_b;
  assign bus.b_ready = rst_n & can_load & win_b;
  assign accept      = bus.a_ready | bus.b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      sel_q    <= 1'b0;
      last_sel <= 1'b1;
    end else if (accept) begin
      data_q   <= win_b ? bus.b_data : bus.a_data;
      sel_q    <= win_b;
      last_sel <= win_b;
      state    <= win_b ? HOLD_B : HOLD_A;
    end else if (bus.out_ready && out_v) begin
      state <= IDLE;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = out_v;
  assign bus.out_sel   = sel_q;

endmodule
